// File: rtl/fetch_branch_ctrl.sv
// fetch_branch_ctrl
// -----------------
// Instruction fetch sequencer with conditional branch/jump resolution.
// A four-state machine walks RST_IDLE -> FETCH -> WAIT -> EXEC -> FETCH.
// WAIT holds a memory read open until mem_ack. EXEC hands the instruction
// to the datapath until exec_done. On the exec_done edge the next pc is
// resolved from the captured instruction and the psr flags present on that edge.
//
// Optional feature: define JAL_EN to add the JAL instruction (jump-and-link)
// and the link_we/link_data return-address ports. The default build has
// neither, and it treats the JAL encoding as an ordinary instruction.
//
// Ports
//   clk         in   clock, all state changes on the rising edge
//   rst_n       in   asynchronous active-low reset
//   psr         in   status flags: C=0, L=2, F=5, Z=6, N=7
//   mem_req     out  instruction read request (FETCH and WAIT)
//   mem_addr    out  read address (= pc)
//   mem_rdata   in   read data, captured on the acknowledging edge
//   mem_ack     in   read acknowledge (only honoured in WAIT)
//   instr       out  current instruction
//   instr_valid out  high while in EXEC
//   exec_done   in   datapath finished (only honoured in EXEC)
//   jtarget     in   register value used as the Jcond/JAL target
//   pc          out  program counter
//   taken       out  one-cycle pulse after a taken control transfer
//   link_we     out  (JAL_EN) one-cycle return-address write strobe
//   link_data   out  (JAL_EN) return address = old pc + 1

module fetch_branch_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] psr,
  output logic        mem_req,
  output logic [20:0] mem_addr,
  input  logic [15:0] mem_rdata,
  input  logic        mem_ack,
  output logic [15:0] instr,
  output logic        instr_valid,
  input  logic        exec_done,
  input  logic [20:0] jtarget,
  output logic [20:0] pc,
  output logic        taken
`ifdef JAL_EN
  ,
  output logic        link_we,
  output logic [20:0] link_data
`endif
);

  typedef enum logic [1:0] {
    RST_IDLE = 2'd0,
    FETCH    = 2'd1,
    WAIT     = 2'd2,
    EXEC     = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] instr_q, instr_d;
  logic [20:0] pc_q, pc_d;
  logic        taken_q, taken_d;
`ifdef JAL_EN
  logic        link_we_q, link_we_d;
  logic [20:0] link_data_q, link_data_d;
`endif

  // Status bits the controller does not look at.
  logic unused_psr;
  assign unused_psr = ^{psr[15:8], psr[4:3], psr[1]};

  // Condition-code evaluation over the five architectural flags.
  function automatic logic cond_true(input logic [3:0] c,
                                     input logic zf, input logic nf,
                                     input logic cf, input logic lf,
                                     input logic ff);
    logic r;
    r = 1'b0;
    case (c)
      4'h0: r = zf;
      4'h1: r = !zf;
      4'h2: r = cf;
      4'h3: r = !cf;
      4'h4: r = lf;
      4'h5: r = !lf;
      4'h6: r = nf;
      4'h7: r = !nf;
      4'h8: r = ff;
      4'h9: r = !ff;
      4'hA: r = !lf && !zf;
      4'hB: r = lf || zf;
      4'hC: r = !nf && !zf;
      4'hD: r = nf || zf;
      4'hE: r = 1'b1;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  logic        is_bcond, is_jcond, cond_ok;
  logic [20:0] pc_inc, pc_branch;
`ifdef JAL_EN
  logic        is_jal;
  assign is_jal = (instr_q[15:12] == 4'b0100) && (instr_q[7:4] == 4'b1000);
`endif

  assign is_bcond  = (instr_q[15:12] == 4'b1100);
  assign is_jcond  = (instr_q[15:12] == 4'b0100) && (instr_q[7:4] == 4'b1100);
  assign cond_ok   = cond_true(instr_q[11:8], psr[6], psr[7], psr[0], psr[2], psr[5]);
  // 21-bit adds wrap naturally, giving modulo-2^21 pc arithmetic.
  assign pc_inc    = pc_q + 21'd1;
  assign pc_branch = pc_q + {{13{instr_q[7]}}, instr_q[7:0]};

  always_comb begin
    state_d = state_q;
    instr_d = instr_q;
    pc_d    = pc_q;
    taken_d = 1'b0;
`ifdef JAL_EN
    link_we_d   = 1'b0;
    link_data_d = link_data_q;
`endif
    case (state_q)
      RST_IDLE: state_d = FETCH;
      FETCH:    state_d = WAIT;
      WAIT: begin
        if (mem_ack) begin
          state_d = EXEC;
          instr_d = mem_rdata;
        end
      end
      EXEC: begin
        if (exec_done) begin
          state_d = FETCH;
          pc_d    = pc_inc;
          if (is_bcond && cond_ok) begin
            pc_d    = pc_branch;
            taken_d = 1'b1;
          end else if (is_jcond && cond_ok) begin
            pc_d    = jtarget;
            taken_d = 1'b1;
          end
`ifdef JAL_EN
          else if (is_jal) begin
            pc_d        = jtarget;
            taken_d     = 1'b1;
            link_we_d   = 1'b1;
            link_data_d = pc_inc;
          end
`endif
        end
      end
      default: state_d = RST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RST_IDLE;
      instr_q <= 16'h0000;
      pc_q    <= 21'h0;
      taken_q <= 1'b0;
    end else begin
      state_q <= state_d;
      instr_q <= instr_d;
      pc_q    <= pc_d;
      taken_q <= taken_d;
    end
  end

`ifdef JAL_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      link_we_q   <= 1'b0;
      link_data_q <= 21'h0;
    end else begin
      link_we_q   <= link_we_d;
      link_data_q <= link_data_d;
    end
  end

  assign link_we   = link_we_q;
  assign link_data = link_data_q;
`endif

  // Decoded from the state register, so an asynchronous reset drops them at once.
  assign mem_req     = (state_q == FETCH) || (state_q == WAIT);
  assign mem_addr    = pc_q;
  assign instr_valid = (state_q == EXEC);
  assign instr       = instr_q;
  assign pc          = pc_q;
  assign taken       = taken_q;

endmodule

// File: tb/tb_fetch_branch_ctrl.sv
module tb_fetch_branch_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] psr;
  logic        mem_req;
  logic [20:0] mem_addr;
  logic [15:0] mem_rdata;
  logic        mem_ack;
  logic [15:0] instr;
  logic        instr_valid;
  logic        exec_done;
  logic [20:0] jtarget;
  logic [20:0] pc;
  logic        taken;
`ifdef JAL_EN
  logic        link_we;
  logic [20:0] link_data;
`endif

  int n_checks = 0;
  int n_errors = 0;

  // Reference program counter kept by the bench.
  int mpc = 0;

  fetch_branch_ctrl dut (
    .clk(clk), .rst_n(rst_n), .psr(psr),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .instr(instr), .instr_valid(instr_valid), .exec_done(exec_done),
    .jtarget(jtarget), .pc(pc), .taken(taken)
`ifdef JAL_EN
    , .link_we(link_we), .link_data(link_data)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Truth of a condition code, written straight from the flag table.
  function automatic bit cond_holds(input int c, input logic [15:0] p);
    bit z, n, cy, l, f;
    z = p[6]; n = p[7]; cy = p[0]; l = p[2]; f = p[5];
    case (c)
      0: return z;        1: return !z;
      2: return cy;       3: return !cy;
      4: return l;        5: return !l;
      6: return n;        7: return !n;
      8: return f;        9: return !f;
      10: return !l && !z; 11: return l || z;
      12: return !n && !z; 13: return n || z;
      14: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // Expected outcome of executing one instruction at pc = mpc.
  task automatic model(input logic [15:0] ins, input logic [20:0] jt, input logic [15:0] p,
                       output int npc, output bit tk, output bit lk);
    int op, c, sub, d;
    op  = int'(ins[15:12]);
    c   = int'(ins[11:8]);
    sub = int'(ins[7:4]);
    d   = int'(ins[7:0]);
    if (d > 127) d = d - 256;
    npc = (mpc + 1) % 2097152;
    tk  = 1'b0;
    lk  = 1'b0;
    if (op == 12 && cond_holds(c, p)) begin
      npc = (mpc + d + 2097152) % 2097152;
      tk  = 1'b1;
    end else if (op == 4 && sub == 12 && cond_holds(c, p)) begin
      npc = int'(jt);
      tk  = 1'b1;
    end
`ifdef JAL_EN
    else if (op == 4 && sub == 8) begin
      npc = int'(jt);
      tk  = 1'b1;
      lk  = 1'b1;
    end
`endif
  endtask

  task automatic wait_req();
    int k;
    k = 0;
    while (!mem_req && k < 20) begin
      tick();
      k++;
    end
    check("mem_req_seen", {31'b0, mem_req}, 32'd1);
  endtask

  // Serve one fetch and execute the instruction, checking the whole transaction.
  task automatic run_instr(input logic [15:0] ins, input logic [20:0] jt, input logic [15:0] p);
    int npc, k, dly;
    bit tk, lk;
    logic [15:0] junk;
    model(ins, jt, p, npc, tk, lk);
    wait_req();
    check("mem_addr", {11'b0, mem_addr}, mpc);
    dly = $urandom_range(0, 2);
    for (int i = 0; i < dly; i++) begin
      exec_done = 1'($urandom_range(0, 1));
      tick();
    end
    mem_rdata = ins;
    mem_ack   = 1'b1;
    k = 0;
    while (!instr_valid && k < 20) begin
      exec_done = 1'($urandom_range(0, 1));
      tick();
      k++;
    end
    exec_done = 1'b0;
    check("instr_valid", {31'b0, instr_valid}, 32'd1);
    check("instr", {16'b0, instr}, {16'b0, ins});
    check("mem_req_exec", {31'b0, mem_req}, 32'd0);
    // Acks during EXEC carry junk that must not be captured.
    junk = ~ins;
    mem_rdata = junk;
    dly = $urandom_range(0, 3);
    for (int i = 0; i < dly; i++) begin
      psr = 16'($urandom);
      mem_ack = 1'($urandom_range(0, 1));
      tick();
    end
    check("instr_hold", {16'b0, instr}, {16'b0, ins});
    mem_ack   = 1'b0;
    psr       = p;
    jtarget   = jt;
    exec_done = 1'b1;
    tick();
    exec_done = 1'b0;
    psr       = 16'($urandom);
    check("pc", {11'b0, pc}, npc);
    check("taken", {31'b0, taken}, {31'b0, tk});
`ifdef JAL_EN
    check("link_we", {31'b0, link_we}, {31'b0, lk});
    if (lk) check("link_data", {11'b0, link_data}, (mpc + 1) % 2097152);
`endif
    mpc = npc;
    tick();
    check("taken_pulse_end", {31'b0, taken}, 32'd0);
`ifdef JAL_EN
    check("link_we_end", {31'b0, link_we}, 32'd0);
`endif
  endtask

  // Always-taken jump used to position pc for directed cases.
  task automatic goto(input logic [20:0] target);
    run_instr(16'h4EC0, target, 16'h0000);
  endtask

  initial begin
    int kind;
    logic [15:0] ins;
    rst_n = 1'b0; psr = 16'h0; mem_rdata = 16'h0; mem_ack = 1'b0;
    exec_done = 1'b0; jtarget = 21'h0;
    #12;
    check("rst_mem_req", {31'b0, mem_req}, 32'd0);
    check("rst_pc", {11'b0, pc}, 32'd0);
    check("rst_instr", {16'b0, instr}, 32'd0);
    check("rst_valid", {31'b0, instr_valid}, 32'd0);
    check("rst_taken", {31'b0, taken}, 32'd0);
`ifdef JAL_EN
    check("rst_link_we", {31'b0, link_we}, 32'd0);
`endif
    @(posedge clk); #1;
    rst_n = 1'b1;
    mpc = 0;

    // Straight-line fetches: addresses 0, 1, 2.
    run_instr(16'h0000, 21'h0, 16'h0);
    run_instr(16'h1234, 21'h0, 16'h0);
    run_instr(16'h0001, 21'h0, 16'h0);

    // Bcond EQ with disp -2, taken and not taken.
    goto(21'h10);
    run_instr(16'hC0FE, 21'h0, 16'h0040);
    goto(21'h10);
    run_instr(16'hC0FE, 21'h0, 16'h0000);

    // Wrap at the top of the address space and below zero.
    goto(21'h1FFFFF);
    run_instr(16'h0000, 21'h0, 16'h0);
    goto(21'h2);
    run_instr(16'hCEFC, 21'h0, 16'h0);

    // Jcond always / never.
    run_instr(16'h4EC3, 21'h0ABCD, 16'h0);
    run_instr(16'h4FC3, 21'h0ABCD, 16'h0);

    // Self-branch with zero displacement.
    run_instr(16'hCE00, 21'h0, 16'h0);

    // JAL encoding.
    goto(21'h5);
    run_instr(16'h4E83, 21'h40, 16'h0);

    // Reset while a fetch is waiting for its ack.
    wait_req();
    tick();
    check("wait_mem_req", {31'b0, mem_req}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("abort_mem_req", {31'b0, mem_req}, 32'd0);
    check("abort_pc", {11'b0, pc}, 32'd0);
    check("abort_instr", {16'b0, instr}, 32'd0);
    mem_rdata = 16'hC0FE;
    mem_ack   = 1'b1;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    mem_ack = 1'b0;
    mpc = 0;
    run_instr(16'h0000, 21'h0, 16'h0);

    // Randomized instruction mix against the reference model.
    for (int i = 0; i < 60; i++) begin
      kind = $urandom_range(0, 4);
      case (kind)
        0: ins = {4'hC, 4'($urandom), 8'($urandom)};
        1: ins = {4'h4, 4'($urandom), 4'hC, 4'($urandom)};
        2: ins = {4'h4, 4'($urandom), 4'h8, 4'($urandom)};
        default: ins = 16'($urandom);
      endcase
      run_instr(ins, 21'($urandom), 16'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/fetch_branch_ctrl.md
FETCH_BRANCH_CTRL -- requirements
Module: fetch_branch_ctrl

Interface
REQ-001 SHALL provide port clk, input, 1: single clock; all state changes on rising edge.
REQ-002 SHALL provide port rst_n, input, 1: asynchronous, active-low reset.
REQ-003 SHALL provide port psr, input, 16: processor status register; flags C=bit0, L=bit2, F=bit5, Z=bit6, N=bit7.
REQ-004 SHALL provide ports mem_req (out, 1), mem_addr (out, 21), mem_rdata (in, 16), mem_ack (in, 1): instruction memory read handshake.
REQ-005 SHALL provide ports instr (out, 16) and instr_valid (out, 1): fetched instruction and hold-valid to the datapath.
REQ-006 SHALL provide port exec_done, input, 1: datapath finished the current instruction; psr is final.
REQ-007 SHALL provide port jtarget, input, 21: register-file value selected by instr[3:0], used as the Jcond/JAL target.
REQ-008 SHALL provide ports pc (out, 21) and taken (out, 1): program counter and one-cycle taken-transfer pulse.
REQ-009 SHALL provide ports link_we (out, 1) and link_data (out, 21): return-address write, present only under JAL_EN.

Function
REQ-010 SHALL implement states RST_IDLE, FETCH, WAIT, EXEC.
REQ-011 SHALL transition RST_IDLE->FETCH unconditionally one cycle after reset release.
REQ-012 SHALL transition FETCH->WAIT unconditionally.
REQ-013 SHALL transition WAIT->EXEC on mem_ack and capture instr<=mem_rdata on that edge; otherwise it SHALL hold WAIT.
REQ-014 SHALL transition EXEC->FETCH on exec_done and update pc on that edge; otherwise it SHALL hold EXEC.
REQ-015 SHALL assert mem_req in FETCH and WAIT only, with mem_addr=pc.
REQ-016 SHALL assert instr_valid in EXEC only.
REQ-017 SHALL ignore mem_ack outside WAIT and exec_done outside EXEC.
REQ-018 SHALL decode Bcond as instr[15:12]=4'b1100 with cond=instr[11:8] and disp=instr[7:0].
REQ-019 SHALL decode Jcond as instr[15:12]=4'b0100, instr[7:4]=4'b1100, with cond=instr[11:8].
REQ-020 SHALL evaluate cond from psr sampled on the exec_done edge: 0 EQ Z; 1 NE !Z; 2 CS C; 3 CC !C; 4 HI L; 5 LS !L; 6 GT N; 7 LE !N; 8 FS F; 9 FC !F; A LO !L&!Z; B HS L|Z; C LT !N&!Z; D GE N|Z; E always; F never.
REQ-021 SHALL set next pc to: taken Bcond pc+sext(disp); taken Jcond jtarget; otherwise pc+1.
REQ-022 SHALL perform all pc arithmetic modulo 2^21 (wrap 0x1FFFFF+1=0x000000; negative displacement wraps below 0).
REQ-023 SHALL pulse taken for exactly the cycle following a taken transfer edge.
REQ-024 SHALL treat disp=0 as a legal self-branch.

Reset
REQ-025 SHALL, while rst_n=0 in any state, immediately force state RST_IDLE, pc=0, instr=0, and instr_valid, mem_req, taken, link_we all 0.
REQ-026 SHALL, on reset during WAIT, drop mem_req without waiting for mem_ack and SHALL ignore any later ack for the aborted fetch.

Configuration
REQ-027 SHALL, with JAL_EN defined, decode JAL as instr[15:12]=4'b0100, instr[7:4]=4'b1000: unconditional, pc<=jtarget, taken pulsed, link_we pulsed one cycle with link_data=old pc+1 (mod 2^21).
REQ-028 SHALL, with JAL_EN undefined, omit link_we/link_data and treat the JAL encoding as non-control (pc+1).

Verification
REQ-029 SHALL verify: reset, mem_ack one cycle after mem_req, exec_done immediately -> mem_addr sequence 0,1,2, with mem_req low in EXEC.
REQ-030 SHALL verify: pc=0x10, instr=0xC0FE, psr[6]=1 -> pc=0x0E, taken=1; same with psr[6]=0 -> pc=0x11, taken=0.
REQ-031 SHALL verify: pc=0x1FFFFF non-control -> pc=0; pc=0x2, instr=0xCEFC -> pc=0x1FFFFE.
REQ-032 SHALL verify: instr=0x4EC3, jtarget=0x0ABCD -> pc=0x0ABCD; instr=0x4FC3 -> pc+1.
REQ-033 SHALL verify: rst_n low mid-WAIT -> mem_req=0 same cycle, pc=0; after release, first mem_addr=0.
REQ-034 SHALL verify with JAL_EN: pc=5, instr=0x4E83, jtarget=0x40 -> link_we pulse, link_data=6, pc=0x40; without JAL_EN -> pc=6.
